ofifo_collect: RTL and testbench
================================

Name: ofifo_collect

Overview:
- Output-side collection buffer for the systolic array.
- Each of COL array columns pushes partial sums independently, with its own valid strobe; columns arrive skewed in time.
- The block re-aligns the columns into complete rows and presents one full row at a time to the downstream reader (SFU / output SRAM writer).
- It is the drain-side counterpart of the row-wise L0 input buffer.

Parameters:
- COL, 8, number of array columns (independent column queues).
- BW, 16, bits per column entry (psum width).
- DEPTH, 64, entries per column queue; must be a power of two, at least 4.
- AW, log2(DEPTH), address width; derived, do not override.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high.
- in, input, COL*BW, column data; column i occupies [(i+1)*BW-1 : i*BW].
- wr, input, COL, per-column write strobe.
- rd, input, 1, pop one aligned row.
- out, output, COL*BW, head row, show-ahead; column i in the same slice as `in`.
- o_valid, output, 1, every column holds at least one entry.
- o_full, output, 1, at least one column is full.
- o_ready, output, 1, equal to ~o_full.
- o_count, output, AW+1, number of complete rows available (minimum occupancy over all columns).
- o_overflow, output, 1, sticky: a write to a full column was dropped.
- o_underflow, output, 1, sticky: rd was asserted while o_valid=0.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - All pointers are cleared; o_overflow and o_underflow are cleared.
  - Resulting outputs: o_valid=0, o_full=0, o_ready=1, o_count=0, out=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all queued data in the same edge.
  - wr and rd are ignored during the reset cycle.
- Per-column queue i:
  - Write and read pointers are AW+1 bits each.
  - empty = (wp == rp).
  - full = (MSBs differ and the low AW bits are equal).
  - occupancy = wp - rp, modulo 2^(AW+1).
  - Pointers wrap naturally at 2^(AW+1).
- Write:
  - If wr[i]=1 and column i is not full at the start of the cycle, mem[wp] <= in slice and wp increments.
  - If wr[i]=1 and column i is full, the write is dropped and o_overflow <= 1. There is no bypass, even when a pop happens in the same cycle.
- Read:
  - If rd=1 and o_valid=1, every column's rp increments in the same edge.
  - If rd=1 and o_valid=0, nothing pops and o_underflow <= 1.
- Simultaneous write and read on one column: both take effect, and occupancy is unchanged.
- Write visibility: data written in cycle t is visible at `out` and counted in o_valid/o_count from cycle t+1. There is no same-cycle write-to-read forwarding.
- out:
  - Combinational from mem[rp] per column.
  - Column slice is forced to 0 while that column is empty.
  - The head row is stable while rd=0.
  - After a pop, the next row appears in the following cycle with zero added latency.
- Flags:
  - o_valid = AND over all columns of ~empty.
  - o_full = OR over all columns of full.
  - o_count = minimum occupancy over all columns, through a combinational min-tree.
- Sticky flags are cleared only by reset.
- Latency: a row becomes readable 1 cycle after the write of its last-arriving column.
- Throughput: 1 row per cycle when every column is written every cycle.

Decomposition:
- Shared package ofifo_pkg:
  - Default COL, BW and DEPTH localparams.
  - An AW computation function (clog2).
  - A pointer-width constant AW+1.
- Sub-module ofifo_col: a single-column circular queue.
  - Ports: clk, reset, wr, in, pop, out, o_empty, o_full, o_occ.
  - Instantiated COL times in a generate loop.
- The top level holds the pop/valid logic, the min-tree for o_count, and the sticky flags.

Test Plan:
1. Skewed fill, default parameters:
   - Stimulus: column i writes value 0x100+i starting at cycle i, one write per column.
   - Required: o_valid rises exactly one cycle after column 7's write; out = {0x107,...,0x100}; o_count=1.
   - Then rd=1 for one cycle: o_valid=0, out=0, o_count=0.
2. Full and overflow:
   - Stimulus: write 64 rows, all columns (data = row index).
   - Required: o_full=1, o_ready=0, o_count=64.
   - Then a 65th write on column 3: dropped, o_overflow=1.
   - Then 64 pops: data returns 0..63 in order.
3. Wrap-around:
   - Stimulus: run 200 rows with concurrent write and rd every cycle after a 10-row prefill.
   - Required: o_count stays at 10; output sequence matches the input sequence with no loss or duplication; pointers pass 2^(AW+1) cleanly.
4. Underflow:
   - Stimulus: only columns 0..6 written, then rd=1.
   - Required: no pop, o_underflow=1, column 7 slice of out = 0, and the other columns' heads are unchanged.
5. Simultaneous write to full column and pop:
   - Stimulus: all columns full, rd=1 and wr=all ones in the same cycle.
   - Required: the write is dropped (o_overflow=1); o_count becomes 63 the next cycle.
6. Reset mid-operation:
   - Stimulus: 5 rows queued, then reset held for one cycle.
   - Required: o_count=0, o_valid=0, sticky flags cleared, out=0.
   - A new write afterwards appears as the head row.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared defaults and width helpers for the output collection FIFO.
package ofifo_pkg;

    localparam int unsigned COL_DEF   = 8;
    localparam int unsigned BW_DEF    = 16;
    localparam int unsigned DEPTH_DEF = 64;

    function automatic int unsigned calc_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned PW_DEF = calc_aw(DEPTH_DEF) + 1;

endpackage

// File: rtl/ofifo_col.sv
// Single-column circular queue with show-ahead head output.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW   = calc_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [BW-1:0] in,
    input  logic          pop,
    output logic [BW-1:0] out,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_occ
);

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic          w_wr_en;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_occ   = r_wp - r_rp;
    // Full is judged before any same-cycle pop, so there is no write bypass.
    assign w_wr_en = wr & ~o_full;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wp[AW-1:0]] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr_en) r_wp <= r_wp + {{AW{1'b0}}, 1'b1};
            if (pop)     r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
        end
    end

    assign out = o_empty ? '0 : r_mem[r_rp[AW-1:0]];

endmodule

// File: rtl/ofifo_collect.sv
// Re-aligns skewed per-column psum streams into complete rows for the drain side.
module ofifo_collect
    import ofifo_pkg::*;
#(
    parameter int unsigned COL   = COL_DEF,
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW   = calc_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COL*BW-1:0] in,
    input  logic [COL-1:0]    wr,
    input  logic              rd,
    output logic [COL*BW-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic [AW:0]       o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    logic [COL-1:0] w_empty;
    logic [COL-1:0] w_full;
    logic [AW:0]    w_occ [COL];
    logic           w_pop;
    logic           r_overflow;
    logic           r_underflow;

    assign w_pop = rd & o_valid;

    for (genvar gi = 0; gi < COL; gi++) begin : g_col
        ofifo_col #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_col (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr[gi]),
            .in      (in[gi*BW +: BW]),
            .pop     (w_pop),
            .out     (out[gi*BW +: BW]),
            .o_empty (w_empty[gi]),
            .o_full  (w_full[gi]),
            .o_occ   (w_occ[gi])
        );
    end

    assign o_valid = ~|w_empty;
    assign o_full  = |w_full;
    assign o_ready = ~o_full;

    // Complete rows available is bounded by the least-filled column.
    always_comb begin
        o_count = w_occ[0];
        for (int i = 1; i < COL; i++) begin
            if (w_occ[i] < o_count) o_count = w_occ[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (|(wr & w_full)) r_overflow  <= 1'b1;
            if (rd && !o_valid) r_underflow <= 1'b1;
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_ofifo_collect.sv
// Scoreboard bench for ofifo_collect at default parameters.
module tb_ofifo_collect;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic              clk;
    logic              reset;
    logic [COL*BW-1:0] in;
    logic [COL-1:0]    wr;
    logic              rd;
    logic [COL*BW-1:0] out;
    logic              o_valid;
    logic              o_full;
    logic              o_ready;
    logic [AW:0]       o_count;
    logic              o_overflow;
    logic              o_underflow;

    ofifo_collect u_dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .wr          (wr),
        .rd          (rd),
        .out         (out),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_ready     (o_ready),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Scoreboard: row k holds the k-th pending entry of each column.
    logic [COL*BW-1:0] sb [$];
    int                cnt [COL];
    bit                m_ovf;
    bit                m_unf;

    task automatic check(input string tag, input logic [COL*BW-1:0] got,
                         input logic [COL*BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [COL*BW-1:0] model_head();
        logic [COL*BW-1:0] r;
        logic [COL*BW-1:0] h;
        r = '0;
        if (sb.size() > 0) begin
            h = sb[0];
            for (int i = 0; i < COL; i++)
                if (cnt[i] > 0) r[i*BW +: BW] = h[i*BW +: BW];
        end
        return r;
    endfunction

    function automatic int model_min();
        int m;
        m = cnt[0];
        for (int i = 1; i < COL; i++) if (cnt[i] < m) m = cnt[i];
        return m;
    endfunction

    function automatic bit model_full();
        bit f;
        f = 0;
        for (int i = 0; i < COL; i++) if (cnt[i] == DEPTH) f = 1;
        return f;
    endfunction

    task automatic check_state();
        check("valid", {127'd0, o_valid}, {127'd0, model_min() > 0});
        check("count", {121'd0, o_count}, 128'(model_min()));
        check("full", {127'd0, o_full}, {127'd0, model_full()});
        check("ready", {127'd0, o_ready}, {127'd0, !model_full()});
        check("overflow", {127'd0, o_overflow}, {127'd0, m_ovf});
        check("underflow", {127'd0, o_underflow}, {127'd0, m_unf});
        check("head", out, model_head());
    endtask

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < COL; i++) cnt[i] = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Drive one cycle, update the scoreboard from pre-edge state, then check.
    task automatic cycle(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
        logic [COL*BW-1:0] row;
        bit v;
        wr = w;
        in = d;
        rd = r;
        v  = model_min() > 0;
        if (r && v) check("pop_data", out, model_head());
        for (int i = 0; i < COL; i++) begin
            if (w[i]) begin
                if (cnt[i] == DEPTH) begin
                    m_ovf = 1;
                end else begin
                    if (cnt[i] == sb.size()) sb.push_back('0);
                    row = sb[cnt[i]];
                    row[i*BW +: BW] = d[i*BW +: BW];
                    sb[cnt[i]] = row;
                    cnt[i]++;
                end
            end
        end
        if (r) begin
            if (v) begin
                void'(sb.pop_front());
                for (int i = 0; i < COL; i++) cnt[i]--;
            end else begin
                m_unf = 1;
            end
        end
        @(posedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr    = COL'($urandom);
        in    = {4{$urandom}};
        rd    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        model_clear();
        check_state();
    endtask

    function automatic logic [COL*BW-1:0] fill_row(input int base, input int step);
        logic [COL*BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = 16'(base + i * step);
        return r;
    endfunction

    logic [COL*BW-1:0] exp_row;
    logic [COL*BW-1:0] saved;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        reset   = 1'b1;
        wr      = '0;
        rd      = 1'b0;
        in      = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Skewed fill, one entry per column, column i at cycle i.
        do_reset();
        check("rst_out", out, '0);
        for (int c = 0; c < COL; c++) begin
            if (c == COL - 1) check("t1_not_yet", {127'd0, o_valid}, '0);
            cycle(COL'(1) << c, fill_row(16'h100, 1), 1'b0);
        end
        exp_row = fill_row(16'h100, 1);
        check("t1_valid", {127'd0, o_valid}, 128'd1);
        check("t1_out", out, exp_row);
        check("t1_count", {121'd0, o_count}, 128'd1);
        cycle('0, '0, 1'b1);
        check("t1_after_pop", out, '0);

        // Fill to full, overflow on one column, drain in order.
        do_reset();
        for (int r = 0; r < DEPTH; r++) cycle('1, fill_row(r, 0), 1'b0);
        check("t2_full", {127'd0, o_full}, 128'd1);
        check("t2_count", {121'd0, o_count}, 128'd64);
        cycle(8'h08, {8{16'hDEAD}}, 1'b0);
        check("t2_ovf", {127'd0, o_overflow}, 128'd1);
        for (int r = 0; r < DEPTH; r++) begin
            check("t2_drain", out, fill_row(r, 0));
            cycle('0, '0, 1'b1);
        end

        // Full columns: write dropped while a pop happens in the same cycle.
        do_reset();
        for (int r = 0; r < DEPTH; r++) cycle('1, fill_row(r * 3, 1), 1'b0);
        cycle('1, {8{16'hBEEF}}, 1'b1);
        check("t5_ovf", {127'd0, o_overflow}, 128'd1);
        check("t5_count", {121'd0, o_count}, 128'd63);

        // Steady-state streaming across pointer wrap.
        do_reset();
        for (int r = 0; r < 10; r++) cycle('1, fill_row(r * 8, 1), 1'b0);
        for (int r = 10; r < 210; r++) begin
            cycle('1, fill_row(r * 8, 1), 1'b1);
            check("t3_count", {121'd0, o_count}, 128'd10);
        end

        // Underflow with column 7 empty.
        do_reset();
        cycle(8'h7F, fill_row(16'h55, 2), 1'b0);
        saved = out;
        cycle('0, '0, 1'b1);
        check("t4_unf", {127'd0, o_underflow}, 128'd1);
        check("t4_col7", {112'd0, out[7*BW +: BW]}, '0);
        check("t4_heads", out, saved);

        // Reset mid-operation discards queued rows and sticky flags.
        cycle('0, '0, 1'b1);
        for (int r = 0; r < 5; r++) cycle('1, fill_row(r + 16'h200, 0), 1'b0);
        do_reset();
        check("t6_count", {121'd0, o_count}, '0);
        check("t6_unf", {127'd0, o_underflow}, '0);
        check("t6_out", out, '0);
        cycle('1, fill_row(16'h777, 1), 1'b0);
        check("t6_new_head", out, fill_row(16'h777, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
